// File: rtl/pifo_io_pkg.sv
// Shared types and constants for the PIFO IO command issuer.
// Contents: command opcodes, response status codes, issuer FSM states and the NO_DATA helper.
package pifo_io_pkg;

    typedef enum logic {
        OP_PUSH = 1'b0,
        OP_POP  = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        RSP_OK      = 2'd0,
        RSP_EMPTY   = 2'd1,
        RSP_DROPPED = 2'd2
    } rsp_status_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_BACKOFF = 2'd2,
        ST_DROP    = 2'd3
    } issuer_state_e;

    localparam int NO_DATA_MAX_W = 256;

    // All-ones "no data" marker of width dw; callers size-cast the result to their data width.
    function automatic logic [NO_DATA_MAX_W-1:0] no_data(input int dw);
        logic [NO_DATA_MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < NO_DATA_MAX_W; i++) begin
            if (i < dw) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/pifo_cmd_issuer_if.sv
// Host command, PIFO port and response signals of the command issuer.
// The slave modport is the issuer's view; the master modport is the host/port side.
interface pifo_cmd_issuer_if #(
    parameter int PTW      = 16,
    parameter int MTW      = 44,
    parameter int TREE_NUM = 24
);
    localparam int DW   = MTW + PTW;
    localparam int TIDW = $clog2(TREE_NUM);

    logic            i_cmd_valid;
    logic            o_cmd_ready;
    logic            i_cmd_op;
    logic [TIDW-1:0] i_cmd_tree_id;
    logic [DW-1:0]   i_cmd_data;

    logic [TIDW-1:0] o_tree_id;
    logic            o_push;
    logic [DW-1:0]   o_push_data;
    logic            o_pop;
    logic            i_task_fail;
    logic [DW-1:0]   i_pop_data;

    logic            o_rsp_valid;
    logic            i_rsp_ready;
    logic [TIDW-1:0] o_rsp_tree_id;
    logic [DW-1:0]   o_rsp_data;
    logic [1:0]      o_rsp_status;

    modport slave (
        input  i_cmd_valid, i_cmd_op, i_cmd_tree_id, i_cmd_data,
        input  i_task_fail, i_pop_data, i_rsp_ready,
        output o_cmd_ready, o_tree_id, o_push, o_push_data, o_pop,
        output o_rsp_valid, o_rsp_tree_id, o_rsp_data, o_rsp_status
    );

    modport master (
        output i_cmd_valid, i_cmd_op, i_cmd_tree_id, i_cmd_data,
        output i_task_fail, i_pop_data, i_rsp_ready,
        input  o_cmd_ready, o_tree_id, o_push, o_push_data, o_pop,
        input  o_rsp_valid, o_rsp_tree_id, o_rsp_data, o_rsp_status
    );

endinterface

// File: rtl/pifo_rsp_fifo.sv
// First-word-fall-through response FIFO with wrap-bit pointers.
// Read data is forced to zero while empty so idle outputs stay quiet.
module pifo_rsp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_arst,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_rd,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_rdata
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             full;
    logic             do_wr;
    logic             do_rd;

    always_comb begin
        o_empty  = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_wr    = i_wr && !full;
        do_rd    = i_rd && !o_empty;
        wr_ptr_d = do_wr ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
        rd_ptr_d = do_rd ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
        o_rdata  = o_empty ? '0 : mem[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only visible between pointers.
    always_ff @(posedge i_clk) begin
        if (do_wr) begin
            mem[wr_ptr_q[AW-1:0]] <= i_wdata;
        end
    end

endmodule

// File: rtl/pifo_cmd_issuer.sv
// Issues host push/pop commands to the PIFO tree port, retrying with back-off on task fail,
// and returns pop results / drop notices through a credit-controlled response FIFO.
module pifo_cmd_issuer
    import pifo_io_pkg::*;
#(
    parameter int PTW         = 16,
    parameter int MTW         = 44,
    parameter int TREE_NUM    = 24,
    parameter int POP_LAT     = 2,
    parameter int RSP_DEPTH   = 4,
    parameter int MAX_RETRY   = 3,
    parameter int BACKOFF_CYC = 2
) (
    input  logic             i_clk,
    input  logic             i_arst,
    pifo_cmd_issuer_if.slave bus
);
    localparam int DW   = MTW + PTW;
    localparam int TIDW = $clog2(TREE_NUM);
    localparam int RW   = $clog2(MAX_RETRY + 2);
    localparam int BW   = $clog2(BACKOFF_CYC + 1);
    localparam int UW   = $clog2(RSP_DEPTH + 1);
    localparam int FW   = TIDW + DW + 2;
    localparam logic [DW-1:0] NO_DATA = DW'(no_data(DW));

    issuer_state_e state_q, state_d;
    op_e           hold_op_q, hold_op_d;
    logic [TIDW-1:0] hold_tid_q, hold_tid_d;
    logic [DW-1:0]   hold_data_q, hold_data_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic [BW-1:0]   backoff_q, backoff_d;
    logic [UW-1:0]   used_q, used_d;
    logic [POP_LAT-1:0]           pipe_vld_q, pipe_vld_d;
    logic [POP_LAT-1:0][TIDW-1:0] pipe_tid_q, pipe_tid_d;

    logic        credit_ok;
    logic        issuing;
    logic        cmd_ready;
    logic        accept;
    logic        push_done;
    logic        pop_done;
    logic        pipe_exit;
    logic        drop_wr;
    logic        rsp_hs;
    logic        fifo_empty;
    logic        fifo_wr;
    logic [FW-1:0] fifo_wdata;
    logic [FW-1:0] fifo_rdata;
    rsp_status_e pop_status;

    // Ready sees the port's same-cycle fail so a clean issue can overlap the next accept.
    always_comb begin
        credit_ok = (used_q < UW'(RSP_DEPTH));
        issuing   = (state_q == ST_ISSUE);
        cmd_ready = !i_arst && credit_ok &&
                    ((state_q == ST_IDLE) || (issuing && !bus.i_task_fail));
        accept    = bus.i_cmd_valid && cmd_ready;
        push_done = issuing && !bus.i_task_fail && (hold_op_q == OP_PUSH);
        pop_done  = issuing && !bus.i_task_fail && (hold_op_q == OP_POP);
        rsp_hs    = !fifo_empty && bus.i_rsp_ready;
    end

    assign bus.o_cmd_ready = cmd_ready;
    assign bus.o_tree_id   = issuing ? hold_tid_q : '0;
    assign bus.o_push      = issuing && (hold_op_q == OP_PUSH);
    assign bus.o_pop       = issuing && (hold_op_q == OP_POP);
    assign bus.o_push_data = issuing ? hold_data_q : '0;

    always_comb begin
        state_d     = state_q;
        hold_op_d   = hold_op_q;
        hold_tid_d  = hold_tid_q;
        hold_data_d = hold_data_q;
        retry_d     = retry_q;
        backoff_d   = backoff_q;
        drop_wr     = 1'b0;
        case (state_q)
            ST_IDLE: ;
            ST_ISSUE: begin
                if (!bus.i_task_fail) begin
                    state_d = ST_IDLE;
                end else if (retry_q == RW'(MAX_RETRY)) begin
                    state_d = ST_DROP;
                end else begin
                    retry_d   = retry_q + RW'(1);
                    backoff_d = '0;
                    state_d   = ST_BACKOFF;
                end
            end
            ST_BACKOFF: begin
                if (backoff_q == BW'(BACKOFF_CYC - 1)) begin
                    state_d = ST_ISSUE;
                end else begin
                    backoff_d = backoff_q + BW'(1);
                end
            end
            ST_DROP: begin
                // A pop result leaving the pipeline owns the FIFO write port this cycle.
                if (!pipe_exit) begin
                    drop_wr = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (accept) begin
            hold_op_d   = op_e'(bus.i_cmd_op);
            hold_tid_d  = bus.i_cmd_tree_id;
            hold_data_d = bus.i_cmd_data;
            retry_d     = '0;
            state_d     = ST_ISSUE;
        end
    end

    // Credits cover the held command, pops in flight and queued responses.
    always_comb begin
        used_d = used_q;
        if (accept)    used_d = used_d + UW'(1);
        if (rsp_hs)    used_d = used_d - UW'(1);
        if (push_done) used_d = used_d - UW'(1);
    end

    always_comb begin
        pipe_vld_d    = '0;
        pipe_tid_d    = '0;
        pipe_vld_d[0] = pop_done;
        pipe_tid_d[0] = hold_tid_q;
        for (int i = 1; i < POP_LAT; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_tid_d[i] = pipe_tid_q[i-1];
        end
        pipe_exit = pipe_vld_q[POP_LAT-1];
    end

    always_comb begin
        pop_status = (bus.i_pop_data == NO_DATA) ? RSP_EMPTY : RSP_OK;
        fifo_wr    = pipe_exit || drop_wr;
        if (pipe_exit) begin
            fifo_wdata = {pipe_tid_q[POP_LAT-1], bus.i_pop_data, pop_status};
        end else begin
            fifo_wdata = {hold_tid_q, NO_DATA, RSP_DROPPED};
        end
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_q     <= ST_IDLE;
            hold_op_q   <= OP_PUSH;
            hold_tid_q  <= '0;
            hold_data_q <= '0;
            retry_q     <= '0;
            backoff_q   <= '0;
            used_q      <= '0;
            pipe_vld_q  <= '0;
            pipe_tid_q  <= '0;
        end else begin
            state_q     <= state_d;
            hold_op_q   <= hold_op_d;
            hold_tid_q  <= hold_tid_d;
            hold_data_q <= hold_data_d;
            retry_q     <= retry_d;
            backoff_q   <= backoff_d;
            used_q      <= used_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_tid_q  <= pipe_tid_d;
        end
    end

    pifo_rsp_fifo #(
        .WIDTH (FW),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .i_clk   (i_clk),
        .i_arst  (i_arst),
        .i_wr    (fifo_wr),
        .i_wdata (fifo_wdata),
        .i_rd    (bus.i_rsp_ready),
        .o_empty (fifo_empty),
        .o_rdata (fifo_rdata)
    );

    assign bus.o_rsp_valid = !fifo_empty;
    assign {bus.o_rsp_tree_id, bus.o_rsp_data, bus.o_rsp_status} = fifo_rdata;

endmodule

// File: tb/tb_pifo_cmd_issuer.sv
// Randomized bench for pifo_cmd_issuer against a transaction-timeline reference model,
// plus a directed pipeline-exit/drop collision on a zero-retry instance.
module tb_pifo_cmd_issuer;

    localparam int PTW         = 16;
    localparam int MTW         = 44;
    localparam int TREE_NUM    = 24;
    localparam int DW          = PTW + MTW;
    localparam int TIDW        = 5;
    localparam int POP_LAT     = 2;
    localparam int RSP_DEPTH   = 4;
    localparam int MAX_RETRY   = 3;
    localparam int BACKOFF_CYC = 2;
    localparam logic [DW-1:0] NO_DATA = '1;

    logic clk = 1'b0;
    logic arst;
    always #5 clk = ~clk;

    pifo_cmd_issuer_if #(.PTW(PTW), .MTW(MTW), .TREE_NUM(TREE_NUM)) b0 ();
    pifo_cmd_issuer_if #(.PTW(PTW), .MTW(MTW), .TREE_NUM(TREE_NUM)) b1 ();

    pifo_cmd_issuer #(
        .PTW(PTW), .MTW(MTW), .TREE_NUM(TREE_NUM), .POP_LAT(POP_LAT),
        .RSP_DEPTH(RSP_DEPTH), .MAX_RETRY(MAX_RETRY), .BACKOFF_CYC(BACKOFF_CYC)
    ) dut (
        .i_clk  (clk),
        .i_arst (arst),
        .bus    (b0)
    );

    pifo_cmd_issuer #(
        .PTW(PTW), .MTW(MTW), .TREE_NUM(TREE_NUM), .POP_LAT(POP_LAT),
        .RSP_DEPTH(RSP_DEPTH), .MAX_RETRY(0), .BACKOFF_CYC(BACKOFF_CYC)
    ) dut_nr (
        .i_clk  (clk),
        .i_arst (arst),
        .bus    (b1)
    );

    typedef struct {
        logic [TIDW-1:0] tid;
        logic [DW-1:0]   data;
        logic [1:0]      status;
        int              vis;
    } rsp_t;

    typedef struct {
        logic [TIDW-1:0] tid;
        int              exit_cyc;
    } pop_t;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    rsp_t rsp_q[$];
    pop_t pop_q[$];
    bit              held;
    bit              h_op;
    logic [TIDW-1:0] h_tid;
    logic [DW-1:0]   h_data;
    int              attempt_at;
    int              fails;
    bit              drop_pending;
    int              drop_at;
    int              m_used;

    bit              drv_valid, drv_op, drv_fail, drv_ready;
    logic [TIDW-1:0] drv_tid;
    logic [DW-1:0]   drv_data, drv_pop_data;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic resetModel();
        rsp_q.delete();
        pop_q.delete();
        held         = 1'b0;
        drop_pending = 1'b0;
        fails        = 0;
        attempt_at   = -1;
        drop_at      = -1;
        m_used       = 0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_rdy"},   b0.o_cmd_ready,   0);
        checkOutput({tag, "_push"},  b0.o_push,        0);
        checkOutput({tag, "_pop"},   b0.o_pop,         0);
        checkOutput({tag, "_tid"},   b0.o_tree_id,     0);
        checkOutput({tag, "_pdat"},  b0.o_push_data,   0);
        checkOutput({tag, "_rv"},    b0.o_rsp_valid,   0);
        checkOutput({tag, "_rtid"},  b0.o_rsp_tree_id, 0);
        checkOutput({tag, "_rdat"},  b0.o_rsp_data,    0);
        checkOutput({tag, "_rst"},   b0.o_rsp_status,  0);
        checkOutput({tag, "_nrrdy"}, b1.o_cmd_ready,   0);
    endtask

    task automatic applyStimulus(input int p_valid, input int p_pop, input int p_fail, input int p_ready);
        drv_valid    = ($urandom_range(99, 0) < p_valid);
        drv_op       = ($urandom_range(99, 0) < p_pop);
        drv_tid      = TIDW'($urandom_range(TREE_NUM - 1, 0));
        drv_data     = DW'({$urandom(), $urandom()});
        drv_fail     = ($urandom_range(99, 0) < p_fail);
        drv_ready    = ($urandom_range(99, 0) < p_ready);
        drv_pop_data = ($urandom_range(3, 0) == 0) ? NO_DATA : DW'({$urandom(), $urandom()});
        b0.i_cmd_valid   = drv_valid;
        b0.i_cmd_op      = drv_op;
        b0.i_cmd_tree_id = drv_tid;
        b0.i_cmd_data    = drv_data;
        b0.i_task_fail   = drv_fail;
        b0.i_rsp_ready   = drv_ready;
        b0.i_pop_data    = drv_pop_data;
    endtask

    // Predict this cycle's outputs from the transaction timeline, compare, then advance the timeline.
    task automatic checkCycle();
        bit   attempt, exp_ready, exp_rv, exit_now;
        rsp_t r;
        pop_t p;
        attempt   = held && !drop_pending && (attempt_at == cyc);
        exp_ready = (m_used < RSP_DEPTH) && (!held || (attempt && !drv_fail));
        exp_rv    = (rsp_q.size() > 0) && (rsp_q[0].vis <= cyc);

        checkOutput("cmd_ready", b0.o_cmd_ready, exp_ready);
        checkOutput("push", b0.o_push, attempt && !h_op);
        checkOutput("pop", b0.o_pop, attempt && h_op);
        checkOutput("tree_id", b0.o_tree_id, attempt ? h_tid : 0);
        if (!attempt || !h_op) checkOutput("push_data", b0.o_push_data, attempt ? h_data : 0);
        checkOutput("rsp_valid", b0.o_rsp_valid, exp_rv);
        if (exp_rv) begin
            checkOutput("rsp_tid", b0.o_rsp_tree_id, rsp_q[0].tid);
            checkOutput("rsp_data", b0.o_rsp_data, rsp_q[0].data);
            checkOutput("rsp_status", b0.o_rsp_status, rsp_q[0].status);
        end

        if (exp_rv && drv_ready) begin
            void'(rsp_q.pop_front());
            m_used--;
        end
        exit_now = 1'b0;
        if (pop_q.size() > 0 && pop_q[0].exit_cyc == cyc) begin
            r.tid    = pop_q[0].tid;
            r.data   = drv_pop_data;
            r.status = (drv_pop_data == NO_DATA) ? 2'd1 : 2'd0;
            r.vis    = cyc + 1;
            rsp_q.push_back(r);
            void'(pop_q.pop_front());
            exit_now = 1'b1;
        end
        if (attempt) begin
            if (drv_fail) begin
                fails++;
                if (fails > MAX_RETRY) begin
                    drop_pending = 1'b1;
                    drop_at      = cyc + 1;
                end else begin
                    attempt_at = cyc + 1 + BACKOFF_CYC;
                end
            end else begin
                if (!h_op) begin
                    m_used--;
                end else begin
                    p.tid      = h_tid;
                    p.exit_cyc = cyc + POP_LAT;
                    pop_q.push_back(p);
                end
                held = 1'b0;
            end
        end else if (drop_pending && drop_at == cyc) begin
            if (exit_now) begin
                drop_at = cyc + 1;
            end else begin
                r.tid    = h_tid;
                r.data   = NO_DATA;
                r.status = 2'd2;
                r.vis    = cyc + 1;
                rsp_q.push_back(r);
                drop_pending = 1'b0;
                held         = 1'b0;
            end
        end
        if (drv_valid && exp_ready) begin
            held       = 1'b1;
            h_op       = drv_op;
            h_tid      = drv_tid;
            h_data     = drv_data;
            fails      = 0;
            attempt_at = cyc + 1;
            m_used++;
        end
        cyc++;
    endtask

    task automatic runPhase(input int n, input int p_valid, input int p_pop, input int p_fail, input int p_ready);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            applyStimulus(p_valid, p_pop, p_fail, p_ready);
            @(negedge clk);
            checkCycle();
        end
    endtask

    // Pop then push on the zero-retry instance so the drop lands on the pop's pipeline exit.
    task automatic collisionTest();
        @(posedge clk); #1;
        b1.i_cmd_valid = 1'b1; b1.i_cmd_op = 1'b1; b1.i_cmd_tree_id = 5'd7;
        b1.i_cmd_data = '0; b1.i_task_fail = 1'b0; b1.i_rsp_ready = 1'b0;
        @(negedge clk);
        checkOutput("col_rdy0", b1.o_cmd_ready, 1);
        @(posedge clk); #1;
        b1.i_cmd_op = 1'b0; b1.i_cmd_tree_id = 5'd3; b1.i_cmd_data = 60'h0ABC;
        @(negedge clk);
        checkOutput("col_pop", b1.o_pop, 1);
        checkOutput("col_pop_tid", b1.o_tree_id, 7);
        checkOutput("col_rdy1", b1.o_cmd_ready, 1);
        @(posedge clk); #1;
        b1.i_cmd_valid = 1'b0; b1.i_task_fail = 1'b1;
        @(negedge clk);
        checkOutput("col_push", b1.o_push, 1);
        checkOutput("col_push_tid", b1.o_tree_id, 3);
        checkOutput("col_rdy2", b1.o_cmd_ready, 0);
        @(posedge clk); #1;
        b1.i_task_fail = 1'b0; b1.i_pop_data = 60'h123;
        @(negedge clk);
        checkOutput("col_rv3", b1.o_rsp_valid, 0);
        checkOutput("col_push3", b1.o_push, 0);
        @(posedge clk); #1;
        b1.i_pop_data = NO_DATA; b1.i_rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("col_rv4", b1.o_rsp_valid, 1);
        checkOutput("col_tid4", b1.o_rsp_tree_id, 7);
        checkOutput("col_dat4", b1.o_rsp_data, 60'h123);
        checkOutput("col_st4", b1.o_rsp_status, 0);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("col_rv5", b1.o_rsp_valid, 1);
        checkOutput("col_tid5", b1.o_rsp_tree_id, 3);
        checkOutput("col_dat5", b1.o_rsp_data, NO_DATA);
        checkOutput("col_st5", b1.o_rsp_status, 2);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("col_rv6", b1.o_rsp_valid, 0);
        checkOutput("col_rdy6", b1.o_cmd_ready, 1);
        b1.i_rsp_ready = 1'b0;
    endtask

    initial begin
        arst = 1'b1;
        b0.i_cmd_valid = 1'b1; b0.i_cmd_op = 1'b0; b0.i_cmd_tree_id = '0; b0.i_cmd_data = '0;
        b0.i_task_fail = 1'b0; b0.i_pop_data = '0; b0.i_rsp_ready = 1'b0;
        b1.i_cmd_valid = 1'b1; b1.i_cmd_op = 1'b0; b1.i_cmd_tree_id = '0; b1.i_cmd_data = '0;
        b1.i_task_fail = 1'b0; b1.i_pop_data = '0; b1.i_rsp_ready = 1'b0;
        resetModel();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkResetOutputs("rst");
        @(posedge clk); #1;
        arst = 1'b0;
        b0.i_cmd_valid = 1'b0;
        b1.i_cmd_valid = 1'b0;

        $display("[TB] collision test on zero-retry instance");
        collisionTest();

        $display("[TB] random phases");
        runPhase(300, 70, 50, 15, 70);
        runPhase(300, 80, 50, 75, 60);
        runPhase(200, 90, 80, 5, 10);
        runPhase(40, 100, 100, 0, 100);

        $display("[TB] reset with pops in flight");
        @(posedge clk); #1;
        arst = 1'b1;
        b0.i_cmd_valid = 1'b1;
        @(negedge clk);
        checkResetOutputs("mrst");
        @(posedge clk);
        @(negedge clk);
        checkResetOutputs("mrst2");
        @(posedge clk); #1;
        arst = 1'b0;
        b0.i_cmd_valid = 1'b0;
        b0.i_pop_data  = 60'h456;
        resetModel();
        @(negedge clk);
        checkOutput("post_rst_rv", b0.o_rsp_valid, 0);
        checkOutput("post_rst_pop", b0.o_pop, 0);

        runPhase(200, 60, 50, 30, 50);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
